mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM encoding, requester
// indices, default widths and an index-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

  localparam int DEF_NREQ   = 3;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: scans from last winner + 1 (wrapping)
// and returns a one-hot grant plus the winner index.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // The previous winner is visited last, so it only wins again when alone.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!any_o && req_i[(int'(last_i) + off) % NREQ]) begin
        any_o = 1'b1;
        gnt_o[(int'(last_i) + off) % NREQ] = 1'b1;
        idx_o = IW'((int'(last_i) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a synchronous single-port RAM; one access
// issued per cycle, acked one cycle later. Optional ownership lock: MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [1:0]               dbg_state_o
);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt in the
  // same cycle; the matching ack is a one-cycle pulse on the following cycle,
  // and for reads rdata carries the RAM word during that ack cycle only.

  localparam int IW = idx_width(NREQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       last_winner_q, last_winner_d;
  logic [NREQ-1:0]     ack_q;
  logic                rd_pend_q;
  logic [DATA_W-1:0]   rdata_hold_q;

  logic [NREQ-1:0]     lock_w;
  logic [NREQ-1:0]     owner_mask;
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                grant;
  logic                lock_held;

`ifdef MEM_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = '0;
`endif

  // Ownership persists while the last winner keeps its lock asserted.
  assign lock_held = (state_q == ST_LOCKED) && lock_w[last_winner_q];

  always_comb begin
    owner_mask = '0;
    owner_mask[last_winner_q] = 1'b1;
    eligible = lock_held ? (req & owner_mask) : req;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i  (eligible),
    .last_i (last_winner_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign grant = pick_any && !reset;

  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      gnt       = pick_gnt;
      mem_en    = 1'b1;
      mem_we    = we[pick_idx];
      mem_addr  = addr[int'(pick_idx) * ADDR_W +: ADDR_W];
      mem_wdata = wdata[int'(pick_idx) * DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    if (grant) begin
      last_winner_d = pick_idx;
      state_d       = lock_w[pick_idx] ? ST_LOCKED : ST_ACTIVE;
    end else if (lock_held) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Reset masks an in-flight ack immediately rather than one edge later.
  assign ack   = reset ? '0 : ack_q;
  assign rdata = reset ? '0 : (rd_pend_q ? mem_rdata : rdata_hold_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_winner_q <= IW'(NREQ - 1);
      ack_q         <= '0;
      rd_pend_q     <= 1'b0;
      rdata_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      ack_q         <= gnt;
      rd_pend_q     <= grant && !we[pick_idx];
      rdata_hold_q  <= rdata;
    end
  end

  assign dbg_state_o = state_q;

endmodule
